// File: rtl/sched_ctrl_pkg.sv
// Shared types and constants for the pipeline scheduler: decode schedule
// types, interrupt defaults and the 2-bit scheduler FSM encoding.
package sched_ctrl_pkg;

    typedef enum logic [3:0] {
        SCHED_NONE          = 4'h0,
        SCHED_PAUSE_FOR_LW  = 4'h1,
        SCHED_PAUSE_FOR_MUL = 4'h2,
        SCHED_BRANCH        = 4'h3,
        SCHED_INT           = 4'h4
    } sched_type_e;

    localparam logic [15:0] SCHED_INT_VECTOR = 16'h0008;
    localparam logic [3:0]  SCHED_ERET_ID    = 4'hF;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_INT_FLUSH  = 2'd1,
        S_ERET_FLUSH = 2'd2
    } sched_state_e;

    // Cause register layout: bit 7 flags a hardware source, low nibble is the id.
    function automatic logic [7:0] sched_cause(input logic hw, input logic [3:0] id);
        return {hw, 3'b000, id};
    endfunction

endpackage

// File: rtl/sched_ctrl.sv
// Pipeline scheduler: turns decode requests and the external interrupt line
// into PC redirect, IF/ID stall/flush and ID/EX bubble; owns int_en/cause/epc.
module sched_ctrl
    import sched_ctrl_pkg::*;
#(
    parameter logic [15:0] INT_VECTOR = SCHED_INT_VECTOR,
    parameter logic [3:0]  ERET_ID    = SCHED_ERET_ID
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sci_pause_request,
    input  logic [3:0]  sci_sched_type,
    input  logic        sci_branch,
    input  logic [15:0] sci_new_pc,
    input  logic [15:0] sci_addr,
    input  logic        sci_int,
    input  logic [3:0]  sci_int_id,
    input  logic        sci_int_set,
    input  logic        sci_int_val,
    input  logic        sci_hw_int,
    input  logic [3:0]  sci_hw_int_id,
    output logic        sco_pc_load,
    output logic [15:0] sco_pc_value,
    output logic        sco_stall_if,
    output logic        sco_stall_id,
    output logic        sco_flush_id,
    output logic        sco_bubble_ex,
    output logic        sco_int_en,
    output logic [7:0]  sco_cause,
    output logic [15:0] sco_epc
);

    sched_state_e state_q, state_d;
    logic         int_en_q, int_en_d;
    logic [7:0]   cause_q, cause_d;
    logic [15:0]  epc_q, epc_d;
    logic         pend_q;
    logic [3:0]   pend_id_q;
    logic         pend_clr;

    logic is_pause, is_eret, is_swint, is_hwint;

    always_comb begin
        is_pause = sci_pause_request && (sci_sched_type == SCHED_PAUSE_FOR_LW);
        is_eret  = sci_int && (sci_int_id == ERET_ID);
        is_swint = sci_int && (sci_int_id != ERET_ID);
        is_hwint = pend_q && int_en_q && !sci_branch;
    end

    always_comb begin
        state_d       = state_q;
        int_en_d      = int_en_q;
        cause_d       = cause_q;
        epc_d         = epc_q;
        pend_clr      = 1'b0;
        sco_pc_load   = 1'b0;
        sco_pc_value  = 16'h0000;
        sco_stall_if  = 1'b0;
        sco_stall_id  = 1'b0;
        sco_flush_id  = 1'b0;
        sco_bubble_ex = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (is_pause) begin
                    // Instruction in ID is held and re-presented next cycle.
                    sco_stall_if  = 1'b1;
                    sco_stall_id  = 1'b1;
                    sco_bubble_ex = 1'b1;
                end else if (is_eret) begin
                    sco_pc_load   = 1'b1;
                    sco_pc_value  = epc_q;
                    sco_flush_id  = 1'b1;
                    sco_bubble_ex = 1'b1;
                    int_en_d      = 1'b1;
                    state_d       = S_ERET_FLUSH;
                end else if (is_swint) begin
                    sco_pc_load   = 1'b1;
                    sco_pc_value  = INT_VECTOR;
                    sco_flush_id  = 1'b1;
                    sco_bubble_ex = 1'b1;
                    epc_d         = sci_addr + 16'd1;
                    cause_d       = sched_cause(1'b0, sci_int_id);
                    int_en_d      = 1'b0;
                    state_d       = S_INT_FLUSH;
                end else if (is_hwint) begin
                    // ID instruction is squashed, so it must be re-executed on return.
                    sco_pc_load   = 1'b1;
                    sco_pc_value  = INT_VECTOR;
                    sco_flush_id  = 1'b1;
                    sco_bubble_ex = 1'b1;
                    epc_d         = sci_addr;
                    cause_d       = sched_cause(1'b1, pend_id_q);
                    int_en_d      = 1'b0;
                    pend_clr      = 1'b1;
                    state_d       = S_INT_FLUSH;
                end else begin
                    if (sci_branch) begin
                        sco_pc_load  = 1'b1;
                        sco_pc_value = sci_new_pc;
                    end
                    if (sci_int_set) begin
                        int_en_d = sci_int_val;
                    end
                end
            end
            S_INT_FLUSH, S_ERET_FLUSH: begin
                sco_flush_id  = 1'b1;
                sco_bubble_ex = 1'b1;
                state_d       = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_RUN;
            int_en_q <= 1'b0;
            cause_q  <= 8'h00;
            epc_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            int_en_q <= int_en_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

    // First pulse wins while pending; a pulse on the clearing cycle re-arms.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q    <= 1'b0;
            pend_id_q <= 4'h0;
        end else if (sci_hw_int && (!pend_q || pend_clr)) begin
            pend_q    <= 1'b1;
            pend_id_q <= sci_hw_int_id;
        end else if (pend_clr) begin
            pend_q    <= 1'b0;
        end
    end

    assign sco_int_en = int_en_q;
    assign sco_cause  = cause_q;
    assign sco_epc    = epc_q;

endmodule

// File: tb/tb_sched_ctrl.sv
// Bench for sched_ctrl: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model of the scheduling rules.
module tb_sched_ctrl;
    import sched_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause_req, branch, int_i, int_set, int_val, hw_int;
    logic [3:0]  stype, int_id, hw_id;
    logic [15:0] new_pc, addr;
    logic        pc_load, stall_if, stall_id, flush_id, bubble_ex, int_en;
    logic [15:0] pc_value, epc;
    logic [7:0]  cause;

    int n_chk  = 0;
    int n_pass = 0;

    sched_ctrl dut (
        .clk(clk), .rst(rst),
        .sci_pause_request(pause_req), .sci_sched_type(stype),
        .sci_branch(branch), .sci_new_pc(new_pc), .sci_addr(addr),
        .sci_int(int_i), .sci_int_id(int_id),
        .sci_int_set(int_set), .sci_int_val(int_val),
        .sci_hw_int(hw_int), .sci_hw_int_id(hw_id),
        .sco_pc_load(pc_load), .sco_pc_value(pc_value),
        .sco_stall_if(stall_if), .sco_stall_id(stall_id),
        .sco_flush_id(flush_id), .sco_bubble_ex(bubble_ex),
        .sco_int_en(int_en), .sco_cause(cause), .sco_epc(epc)
    );

    always #5 clk = ~clk;

    // Architectural model: a flush cycle is simply "the cycle after an entry/ERET".
    logic        m_en, m_pend, m_after_redirect;
    logic [7:0]  m_cause;
    logic [15:0] m_epc;
    logic [3:0]  m_pid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_en = 0; m_pend = 0; m_after_redirect = 0;
        m_cause = 0; m_epc = 0; m_pid = 0;
    endtask

    task automatic idle();
        pause_req = 0; stype = SCHED_NONE; branch = 0; new_pc = 0; addr = 0;
        int_i = 0; int_id = 0; int_set = 0; int_val = 0; hw_int = 0; hw_id = 0;
    endtask

    // Entered just after a negedge with inputs driven; leaves at the next negedge.
    task automatic cyc();
        logic        e_load, e_si, e_sd, e_fl, e_bx, took_hw, redirect;
        logic [15:0] e_pc;
        logic        n_en;
        logic [7:0]  n_cause;
        logic [15:0] n_epc;
        logic        pend_left;
        #1;
        e_load = 0; e_pc = 0; e_si = 0; e_sd = 0; e_fl = 0; e_bx = 0;
        took_hw = 0; redirect = 0;
        n_en = m_en; n_cause = m_cause; n_epc = m_epc;
        if (m_after_redirect) begin
            e_fl = 1; e_bx = 1;
        end else if (pause_req && stype == SCHED_PAUSE_FOR_LW) begin
            e_si = 1; e_sd = 1; e_bx = 1;
        end else if (int_i && int_id == 4'hF) begin
            e_load = 1; e_pc = m_epc; e_fl = 1; e_bx = 1;
            n_en = 1; redirect = 1;
        end else if (int_i) begin
            e_load = 1; e_pc = 16'h0008; e_fl = 1; e_bx = 1;
            n_epc = addr + 16'd1; n_cause = {4'h0, int_id}; n_en = 0; redirect = 1;
        end else if (m_pend && m_en && !branch) begin
            e_load = 1; e_pc = 16'h0008; e_fl = 1; e_bx = 1;
            n_epc = addr; n_cause = 8'h80 | m_pid; n_en = 0; redirect = 1; took_hw = 1;
        end else begin
            if (branch) begin e_load = 1; e_pc = new_pc; end
            if (int_set) n_en = int_val;
        end
        chk("pc_load",   pc_load,   e_load);
        chk("pc_value",  pc_value,  e_pc);
        chk("stall_if",  stall_if,  e_si);
        chk("stall_id",  stall_id,  e_sd);
        chk("flush_id",  flush_id,  e_fl);
        chk("bubble_ex", bubble_ex, e_bx);
        chk("int_en",    int_en,    m_en);
        chk("cause",     cause,     m_cause);
        chk("epc",       epc,       m_epc);
        @(posedge clk);
        pend_left = m_pend && !took_hw;
        if (hw_int && !pend_left) begin m_pend = 1; m_pid = hw_id; end
        else m_pend = pend_left;
        m_en = n_en; m_cause = n_cause; m_epc = n_epc;
        m_after_redirect = redirect;
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 0;
        model_reset();
        #2;
        chk("rst_int_en", int_en, 1'b0);
        chk("rst_cause",  cause,  8'h00);
        chk("rst_epc",    epc,    16'h0000);
        chk("rst_outs",   {pc_load, stall_if, stall_id, flush_id, bubble_ex}, 5'b0);
        chk("rst_pcval",  pc_value, 16'h0000);
        @(negedge clk); @(negedge clk);
        rst = 1;
        cyc();

        // Load-use pause for exactly one cycle.
        pause_req = 1; stype = SCHED_PAUSE_FOR_LW; addr = 16'h0050; cyc();
        idle(); addr = 16'h0051; cyc();
        // A non-LW pause type does not stall.
        pause_req = 1; stype = SCHED_PAUSE_FOR_MUL; cyc();

        // Software INT 3 at 0x0100.
        idle(); int_i = 1; int_id = 4'h3; addr = 16'h0100;
        #1 chk("swint_pcval", pc_value, 16'h0008);
        cyc();
        idle(); addr = 16'h0101;
        #1 chk("swint_flush2", flush_id, 1'b1);
        cyc();
        chk("swint_epc",   epc,    16'h0101);
        chk("swint_cause", cause,  8'h03);
        chk("swint_en",    int_en, 1'b0);

        // ERET returns to 0x0101.
        int_i = 1; int_id = 4'hF; addr = 16'h0009;
        #1 chk("eret_pcval", pc_value, 16'h0101);
        cyc();
        idle(); cyc();
        chk("eret_en", int_en, 1'b1);

        // HW int 5 held pending while disabled, taken after MTIH enables.
        int_set = 1; int_val = 0; cyc();
        idle(); hw_int = 1; hw_id = 4'h5; addr = 16'h0200; cyc();
        idle(); addr = 16'h0201; cyc();
        cyc();
        int_set = 1; int_val = 1; addr = 16'h0300; cyc();
        idle(); addr = 16'h0301; cyc();
        chk("hw_cause", cause, 8'h85);
        chk("hw_epc",   epc,   16'h0301);
        idle(); cyc();

        // Pending HW int deferred past a branch into the delay slot.
        int_set = 1; int_val = 1; cyc();
        idle(); hw_int = 1; hw_id = 4'h6; addr = 16'h0400; cyc();
        idle(); branch = 1; new_pc = 16'h0200; addr = 16'h0401;
        #1 chk("br_pcval", pc_value, 16'h0200);
        cyc();
        idle(); addr = 16'h0402; cyc();
        chk("ds_epc",   epc,   16'h0402);
        chk("ds_cause", cause, 8'h86);
        idle(); cyc();

        // epc wraps when INT sits at the top of memory.
        int_i = 1; int_id = 4'h1; addr = 16'hFFFF; cyc();
        idle(); cyc();
        chk("wrap_epc", epc, 16'h0000);

        // Reset mid-flush clears state immediately.
        int_i = 1; int_id = 4'h2; addr = 16'h0777; cyc();
        idle(); rst = 0;
        #1;
        model_reset();
        chk("midrst_flush", flush_id, 1'b0);
        chk("midrst_cause", cause,    8'h00);
        chk("midrst_epc",   epc,      16'h0000);
        @(negedge clk);
        rst = 1;
        cyc();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            pause_req = ($urandom_range(0, 5) == 0);
            stype     = 4'($urandom_range(0, 4));
            branch    = ($urandom_range(0, 3) == 0);
            new_pc    = 16'($urandom);
            addr      = 16'($urandom);
            int_i     = ($urandom_range(0, 9) == 0);
            int_id    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            int_set   = ($urandom_range(0, 5) == 0);
            int_val   = ($urandom_range(0, 3) != 0);
            hw_int    = ($urandom_range(0, 6) == 0);
            hw_id     = 4'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sched_ctrl.md
# sched_ctrl

Pipeline scheduler for the 16-bit five-stage core. It receives the decode stage's requests (load-use pause, branch redirect, INT/ERET, MTIH interrupt-enable writes) plus one external hardware interrupt line. From these it drives PC redirect, IF/ID stall and flush, and ID/EX bubble. It owns the interrupt-enable bit, the cause register and the EPC, which it feeds back to decode for MFIH.

## Interface

Parameters:
- INT_VECTOR, 16'h0008, PC loaded on interrupt entry
- ERET_ID, 4'hF, INT number treated as ERET

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- sci_pause_request  in  1  decode pause request
- sci_sched_type  in  4  decode schedule type; SCHED_PAUSE_FOR_LW is the only pausing type
- sci_branch  in  1  decode branch taken
- sci_new_pc  in  16  branch target
- sci_addr  in  16  PC of the instruction in ID
- sci_int  in  1  INT instruction in ID
- sci_int_id  in  4  INT number
- sci_int_set  in  1  MTIH changes the enable bit (strobe)
- sci_int_val  in  1  new enable value
- sci_hw_int  in  1  hardware interrupt pulse
- sci_hw_int_id  in  4  hardware interrupt number
- sco_pc_load  out  1  load PC with sco_pc_value
- sco_pc_value  out  16  next PC when loading
- sco_stall_if  out  1  hold PC
- sco_stall_id  out  1  hold IF/ID register
- sco_flush_id  out  1  clear IF/ID to NOP
- sco_bubble_ex  out  1  write NOP into ID/EX
- sco_int_en  out  1  interrupt enable
- sco_cause  out  8  {hw, 3'b0, id}
- sco_epc  out  16  return PC

## Operation

- FSM states: S_RUN, S_INT_FLUSH, S_ERET_FLUSH.
- Registers: int_en, cause, epc, pend, pend_id, state.
- Evaluation order in S_RUN, first match wins:
  1. Load-use pause (sci_pause_request and type PAUSE_FOR_LW): stall_if=stall_id=bubble_ex=1. No other action. Any INT or branch in ID is re-presented next cycle.
  2. ERET (sci_int, id==ERET_ID): pc_load with epc, flush_id=1, bubble_ex=1. int_en<=1. Go to S_ERET_FLUSH.
  3. Software INT (other id): taken regardless of int_en. epc<=sci_addr+1, cause<={1'b0,3'b0,id}, int_en<=0. pc_load with INT_VECTOR, flush_id=1, bubble_ex=1. Go to S_INT_FLUSH.
  4. Hardware interrupt (pend & int_en & !sci_branch): epc<=sci_addr (the ID instruction is squashed and re-executed), cause<={1'b1,3'b0,pend_id}, int_en<=0, pend<=0. Outputs and next state as for item 3.
  5. Branch: pc_load with sci_new_pc. No flush: there is one architectural delay slot.
- S_INT_FLUSH and S_ERET_FLUSH last one cycle. Each asserts flush_id and bubble_ex to squash the wrong-path fetch, ignores all decode requests, then returns to S_RUN.
- Pending latch: a sci_hw_int pulse with pend=0 sets pend and stores the id. Further pulses while pend=1 are ignored (first wins). A pulse in the same cycle pend clears is accepted as a new pending request.
- MTIH: sci_int_set loads int_en<=sci_int_val, but only when no interrupt entry or ERET happens that cycle; entry/ERET wins. Ignored in flush states.
- Widths: sci_addr+1 wraps modulo 2^16.

## Timing

- All outputs are combinational from the inputs and registered state; there is no output register. Register updates happen at the rising clk.
- Interrupt entry: pc_load in the detection cycle, one flush cycle follows, and the vector instruction reaches ID 2 cycles after detection.
- The pause lasts exactly the cycles in which decode asserts the request; normally one.
- Reset (any time, including mid-flush): state=S_RUN, int_en=0, cause=0, epc=0, pend=0. Combinational outputs are all 0 when inputs are idle; sco_pc_value=0.

## Structure

- Shared package/defines: SCHED_* types, the INT_VECTOR default, ERET_ID, and the FSM state encoding (2 bits).
- No sub-module is needed. The pending-interrupt latch is a small always block inside the module.

## Test plan

- Load-use: pause_request=1 with type PAUSE_FOR_LW for one cycle -> stall_if=stall_id=bubble_ex=1 for that cycle only; no pc_load.
- Software INT 3 at sci_addr=16'h0100 -> pc_load with 16'h0008, epc=16'h0101, cause=8'h03, int_en=0; flush_id high for 2 cycles.
- ERET after that INT -> pc_load with 16'h0101, int_en=1, one S_ERET_FLUSH cycle.
- hw_int id 5 with int_en=0, then MTIH sets int_en=1 -> entry taken the cycle after int_en rises; cause=8'h85, epc=current sci_addr.
- hw_int pending while sci_branch=1 to 16'h0200 -> branch is taken; the interrupt is taken on the next non-branch cycle and epc equals the delay-slot address.
- Assert rst low during S_INT_FLUSH -> every register is cleared immediately; the next cycle is in S_RUN with no flush.
